// File: rtl/cory_merge2_pkg.sv
// Shared definitions for the two-input stream merge: arbitration policy codes
// and the width of a buffered {source, data} entry.
package cory_merge2_pkg;

   localparam int CORY_MERGE_RR    = 0;
   localparam int CORY_MERGE_FIXED = 1;

   function automatic int cory_merge_ent_w(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/cory_merge2_buf.sv
// Two-entry output FIFO for the merge; space comes from the registered count
// only, so upstream readies never see the downstream ready.
module cory_merge2_buf #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_d,
   output logic         space,
   output logic         out_v,
   output logic [W-1:0] out_d,
   input  logic         out_r
);

   logic [W-1:0] mem [2];
   logic [1:0]   count;
   logic         wp;
   logic         rp;
   logic         wr;
   logic         pop;

   assign space = (count != 2'd2);
   assign out_v = (count != 2'd0);
   assign out_d = mem[rp];
   assign wr    = push && space;
   assign pop   = out_v && out_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         count  <= 2'd0;
         wp     <= 1'b0;
         rp     <= 1'b0;
      end else begin
         if (wr) begin
            mem[wp] <= push_d;
            wp      <= ~wp;
         end
         if (pop) rp <= ~rp;
         case ({wr, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cory_merge2.sv
// Two-to-one valid/ready stream merge; each output beat carries the index of
// the input it came from so a downstream demux can route responses back.
module cory_merge2
   import cory_merge2_pkg::*;
#(
   parameter int N    = 8,
   parameter int PRIO = CORY_MERGE_RR
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_a0_v,
   input  logic [N-1:0] i_a0_d,
   output logic         o_a0_r,
   input  logic         i_a1_v,
   input  logic [N-1:0] i_a1_d,
   output logic         o_a1_r,
   output logic         o_z_v,
   output logic [N-1:0] o_z_d,
   output logic         o_z_s,
   input  logic         i_z_r
);

   localparam int EW = cory_merge_ent_w(N);

   logic          space;
   logic          last;
   logic          g0;
   logic          g1;
   logic [EW-1:0] push_d;
   logic [EW-1:0] out_d;

   // Input 0 wins a contest under fixed priority, or when input 1 went last.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (!reset && space) begin
         if (i_a0_v && (!i_a1_v || PRIO == CORY_MERGE_FIXED || last))
            g0 = 1'b1;
         else if (i_a1_v)
            g1 = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   last <= 1'b1;
      else if (g0) last <= 1'b0;
      else if (g1) last <= 1'b1;
   end

   assign o_a0_r = g0;
   assign o_a1_r = g1;
   assign push_d = {g1, (g1 ? i_a1_d : i_a0_d)};

   cory_merge2_buf #(.W(EW)) u_buf (
      .clk    (clk),
      .reset  (reset),
      .push   (g0 | g1),
      .push_d (push_d),
      .space  (space),
      .out_v  (o_z_v),
      .out_d  (out_d),
      .out_r  (i_z_r)
   );

   assign o_z_s = out_d[EW-1];
   assign o_z_d = out_d[N-1:0];

endmodule

// File: tb/tb_cory_merge2.sv
// Directed and random checks for cory_merge2: round-robin and fixed-priority
// instances share one set of input stimulus.
module tb_cory_merge2;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         a0_v = 1'b0, a1_v = 1'b0, z_r = 1'b0;
   logic [N-1:0] a0_d = '0, a1_d = '0;

   logic         r_a0_r, r_a1_r, r_z_v, r_z_s;
   logic [N-1:0] r_z_d;
   logic         f_a0_r, f_a1_r, f_z_v, f_z_s;
   logic [N-1:0] f_z_d;

   cory_merge2 #(.N(N), .PRIO(0)) dut_rr (
      .clk(clk), .reset(reset),
      .i_a0_v(a0_v), .i_a0_d(a0_d), .o_a0_r(r_a0_r),
      .i_a1_v(a1_v), .i_a1_d(a1_d), .o_a1_r(r_a1_r),
      .o_z_v(r_z_v), .o_z_d(r_z_d), .o_z_s(r_z_s), .i_z_r(z_r)
   );

   cory_merge2 #(.N(N), .PRIO(1)) dut_fx (
      .clk(clk), .reset(reset),
      .i_a0_v(a0_v), .i_a0_d(a0_d), .o_a0_r(f_a0_r),
      .i_a1_v(a1_v), .i_a1_d(a1_d), .o_a1_r(f_a1_r),
      .o_z_v(f_z_v), .o_z_d(f_z_d), .o_z_s(f_z_s), .i_z_r(z_r)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Directed stream driver state
   bit         use_f;
   bit         en0, en1;
   int         lim0, lim1, idx0, idx1;
   logic [7:0] base0, base1;
   logic       s_a0r, s_a1r, s_zv, s_zs;
   logic [7:0] s_zd;

   task automatic apply();
      a0_v = en0 && (idx0 < lim0);
      a1_v = en1 && (idx1 < lim1);
      a0_d = base0 + idx0[7:0];
      a1_d = base1 + idx1[7:0];
   endtask

   // One cycle: sample away from the edge, then advance on handshakes.
   task automatic cyc();
      @(negedge clk);
      s_a0r = use_f ? f_a0_r : r_a0_r;
      s_a1r = use_f ? f_a1_r : r_a1_r;
      s_zv  = use_f ? f_z_v  : r_z_v;
      s_zd  = use_f ? f_z_d  : r_z_d;
      s_zs  = use_f ? f_z_s  : r_z_s;
      @(posedge clk);
      #1;
      if (a0_v && s_a0r) idx0++;
      if (a1_v && s_a1r) idx1++;
      apply();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      en0 = 0; en1 = 0; idx0 = 0; idx1 = 0; z_r = 1'b0;
      apply();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rr_exp [8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
   logic       rr_s   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] fx_exp [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
   logic       fx_s   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   logic [7:0] q0 [$];
   logic [7:0] q1 [$];
   logic       ra0, ra1, pv, pzr, ps;
   logic [7:0] pd;

   initial begin
      base0 = 8'h00; base1 = 8'h00; lim0 = 0; lim1 = 0; use_f = 0;

      // Reset state
      #2;
      chk("rst_zv", r_z_v, 0);
      chk("rst_zd", r_z_d, 0);
      chk("rst_zs", r_z_s, 0);
      chk("rst_rdy", {r_a0_r, r_a1_r}, 0);

      // Round-robin
      use_f = 0;
      do_reset();
      base0 = 8'h10; base1 = 8'h20; lim0 = 4; lim1 = 4; en0 = 1; en1 = 1; z_r = 1'b1;
      apply();
      cyc();
      chk("rr_first_zv", s_zv, 0);
      chk("rr_first_gnt", {s_a0r, s_a1r}, 2'b10);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk($sformatf("rr_zv[%0d]", k), s_zv, 1);
         chk($sformatf("rr_zd[%0d]", k), s_zd, rr_exp[k]);
         chk($sformatf("rr_zs[%0d]", k), s_zs, rr_s[k]);
         chk($sformatf("rr_excl[%0d]", k), s_a0r & s_a1r, 0);
      end

      // Fixed priority
      use_f = 1;
      do_reset();
      base0 = 8'h10; base1 = 8'h20; lim0 = 4; lim1 = 4; en0 = 1; en1 = 1; z_r = 1'b1;
      apply();
      cyc();
      chk("fx_first_zv", s_zv, 0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk($sformatf("fx_zv[%0d]", k), s_zv, 1);
         chk($sformatf("fx_zd[%0d]", k), s_zd, fx_exp[k]);
         chk($sformatf("fx_zs[%0d]", k), s_zs, fx_s[k]);
      end

      // Backpressure
      use_f = 0;
      do_reset();
      base1 = 8'h30; lim1 = 100; en1 = 1; z_r = 1'b0;
      apply();
      cyc(); chk("bp_r_c0", s_a1r, 1);
      cyc(); chk("bp_r_c1", s_a1r, 1); chk("bp_zd_c1", s_zd, 8'h30);
      cyc(); chk("bp_r_c2", s_a1r, 0); chk("bp_zd_c2", s_zd, 8'h30);
      cyc(); chk("bp_r_c3", s_a1r, 0); chk("bp_zd_c3", s_zd, 8'h30); chk("bp_zs_c3", s_zs, 1);
      z_r = 1'b1;
      cyc(); chk("bp_r_pop", s_a1r, 0); chk("bp_zd_pop", s_zd, 8'h30);
      cyc(); chk("bp_r_back", s_a1r, 1); chk("bp_zd_c5", s_zd, 8'h31);
      cyc(); chk("bp_r_c6", s_a1r, 1); chk("bp_zd_c6", s_zd, 8'h32);
      cyc(); chk("bp_zd_c7", s_zd, 8'h33); chk("bp_zv_c7", s_zv, 1);
      en1 = 0;
      apply();

      // Asynchronous reset with the buffer full
      do_reset();
      base1 = 8'h50; lim1 = 10; en1 = 1; z_r = 1'b0;
      apply();
      cyc(); cyc();
      @(negedge clk);
      chk("rs_full_zv", r_z_v, 1);
      chk("rs_full_r1", r_a1_r, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("rs_async_zv", r_z_v, 0);
      chk("rs_async_zd", r_z_d, 0);
      chk("rs_async_zs", r_z_s, 0);
      chk("rs_async_rdy", {r_a0_r, r_a1_r}, 0);
      en1 = 0; idx1 = 0;
      apply();
      @(negedge clk);
      reset = 1'b0;
      base0 = 8'h60; base1 = 8'h70; lim0 = 1; lim1 = 1; en0 = 1; en1 = 1;
      apply();
      #1;
      chk("rs_both_gnt", {r_a0_r, r_a1_r}, 2'b10);
      @(posedge clk);
      #1;
      en0 = 0; en1 = 0;
      apply();
      @(negedge clk);
      chk("rs_first_zd", r_z_d, 8'h60);
      chk("rs_first_zs", r_z_s, 0);

      // Only input 1 presented after reset
      do_reset();
      base1 = 8'h71; lim1 = 1; en1 = 1;
      apply();
      #1;
      chk("rs_one_gnt", {r_a0_r, r_a1_r}, 2'b01);
      @(posedge clk);
      #1;
      en1 = 0;
      apply();
      @(negedge clk);
      chk("rs_one_zd", r_z_d, 8'h71);
      chk("rs_one_zs", r_z_s, 1);

      // Push and pop together at count 1 across pointer wrap
      do_reset();
      base0 = 8'h40; lim0 = 6; en0 = 1; z_r = 1'b1;
      apply();
      cyc();
      chk("pp_gnt0", s_a0r, 1);
      chk("pp_zv0", s_zv, 0);
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk($sformatf("pp_zv[%0d]", k), s_zv, 1);
         chk($sformatf("pp_zd[%0d]", k), s_zd, 8'h40 + k[7:0]);
         chk($sformatf("pp_gnt[%0d]", k), s_a0r, (k < 5) ? 1 : 0);
      end
      en0 = 0;
      apply();

      // Random traffic against a per-source scoreboard
      do_reset();
      pv = 1'b0; pzr = 1'b0; ps = 1'b0; pd = '0;
      for (int i = 0; i < 420; i++) begin
         z_r = (i >= 400) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk);
         ra0 = r_a0_r;
         ra1 = r_a1_r;
         chk("rnd_excl", ra0 & ra1, 0);
         chk("rnd_g0_nov", ra0 & ~a0_v, 0);
         chk("rnd_g1_nov", ra1 & ~a1_v, 0);
         if (pv && !pzr) begin
            chk("rnd_hold_v", r_z_v, 1);
            chk("rnd_hold_d", r_z_d, pd);
            chk("rnd_hold_s", r_z_s, ps);
         end
         if (r_z_v && z_r) begin
            if (r_z_s) begin
               if (q1.size() == 0) chk("rnd_q1_empty", 1, 0);
               else chk("rnd_d1", r_z_d, q1.pop_front());
            end else begin
               if (q0.size() == 0) chk("rnd_q0_empty", 1, 0);
               else chk("rnd_d0", r_z_d, q0.pop_front());
            end
         end
         if (a0_v && ra0) q0.push_back(a0_d);
         if (a1_v && ra1) q1.push_back(a1_d);
         pv = r_z_v; pzr = z_r; pd = r_z_d; ps = r_z_s;
         @(posedge clk);
         #1;
         if (!(a0_v && !ra0)) begin
            a0_v = (i < 400) && ($urandom_range(0, 3) != 0);
            a0_d = 8'($urandom);
         end
         if (!(a1_v && !ra1)) begin
            a1_v = (i < 400) && ($urandom_range(0, 3) != 0);
            a1_d = 8'($urandom);
         end
      end
      chk("rnd_q0_drained", q0.size(), 0);
      chk("rnd_q1_drained", q1.size(), 0);
      chk("rnd_idle_zv", r_z_v, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/cory_merge2.md
# cory_merge2

Two-input to one-output stream merge: it arbitrates between two valid/ready input streams and forwards one beat per cycle to a single output. The output carries a select bit naming the source input, so a downstream `cory_demux2` can route responses back by that bit. A 2-entry output buffer gives full throughput, and `o_a0_r`/`o_a1_r` have no combinational path from `i_z_r`.

## Interface
Parameters:
- `N`, 8, data width of each input and of the output.
- `PRIO`, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (input 0 always wins).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `i_a0_v` in 1: input 0 valid.
- `i_a0_d` in N: input 0 data.
- `o_a0_r` out 1: input 0 ready (grant).
- `i_a1_v` in 1: input 1 valid.
- `i_a1_d` in N: input 1 data.
- `o_a1_r` out 1: input 1 ready (grant).
- `o_z_v` out 1: output valid.
- `o_z_d` out N: output data.
- `o_z_s` out 1: source of the current output beat (0 or 1). Qualified by `o_z_v`.
- `i_z_r` in 1: output ready.

## Operation
- **Handshake.** A beat transfers when valid and ready are both high on a rising edge. Once asserted, valid and data must hold until the transfer. Ready may depend on valid. Valid never depends on ready.
- **Output buffer.**
  - 2-entry FIFO holding {s, d}, with a count of 0..2 and 1-bit write and read pointers that wrap.
  - `space` = (count < 2), taken from the registered count only.
- **Arbitration.** Only evaluated when `space` = 1.
  - Only one valid: that input is granted.
  - Both valid, `PRIO`=0: grant the input that is not `last`. `last` is a 1-bit register updated to the granted index on each accepted beat.
  - Both valid, `PRIO`=1: input 0 is granted.
  - At most one of `o_a0_r`/`o_a1_r` is high in any cycle. A grant with its valid low is forbidden.
- **Write.** An accepted beat writes {granted index, data} at the write pointer.
- **Read.**
  - `o_z_v` = (count ≠ 0). `o_z_d`/`o_z_s` come from the read-pointer entry.
  - When `o_z_v && i_z_r`, the read pointer advances.
- **Count update.**
  - Simultaneous write and read: count is unchanged and both pointers advance.
  - Count = 2: no grant. Both inputs stall even if the output is popping that cycle.
  - Count = 0: the output is invalid, and a write this cycle shows at the output next cycle. There is no flow-through.
- **Reset** (asynchronous; outputs are forced immediately on assertion):
  - count = 0, pointers = 0, `last` = 1, so input 0 wins the first contest.
  - Storage entries are cleared to 0.
  - Reset values: `o_z_v`=0, `o_z_d`=0, `o_z_s`=0, `o_a0_r`=0, `o_a1_r`=0.
  - While `reset` is high, both readies are forced to 0.
  - Beats in flight when reset asserts are discarded. Sources must re-present them.

## Timing
- **Latency.** A beat accepted at edge k appears on `o_z_v` after edge k; it is valid in cycle k+1.
- **Throughput.** One beat per cycle sustained when `i_z_r` is held high.
- **Backpressure.**
  - With `i_z_r` low, at most two more beats are accepted, then readies drop.
  - After `i_z_r` rises, readies return one cycle after the first pop, when count falls below 2.
- **Round-robin fairness.** With both inputs continuously valid and the output always ready, grants alternate 0,1,0,1…
- **Combinational paths.** `o_a*_r` depend on `i_a0_v`, `i_a1_v`, count and `last`, never on `i_z_r`. Output signals are purely registered.

## Structure
- Shared package contents:
  - `CORY_MERGE_RR` = 0 and `CORY_MERGE_FIXED` = 1 for `PRIO`.
  - The {s, d} entry width, N+1.
- One sub-module, `cory_merge2_buf`: the 2-entry FIFO with `clk`/`reset`, push {s, d}, `space`, and the output valid/data/ready. Arbitration and `last` stay in `cory_merge2`.

## Test plan
- **Reset.** Assert `reset` mid-stream with count=2 → all outputs 0 immediately. After release, the first beat out is from whichever input is presented first. With both valid, input 0 wins.
- **Round-robin.** `PRIO`=0; stream input 0 data 0x10..0x13 and input 1 data 0x20..0x23, both always valid; `i_z_r`=1.
  - Output order: 0x10,0x20,0x11,0x21,…, with `o_z_s` = 0,1,0,1…
  - One beat per cycle; first `o_z_v` the cycle after the first accept.
- **Fixed priority.** `PRIO`=1, same stimulus → 0x10..0x13 all first (`o_z_s`=0), then 0x20..0x23.
- **Backpressure.** Hold `i_z_r`=0 and present input 1 continuously.
  - Exactly 2 beats are accepted, then `o_a1_r`=0.
  - Raise `i_z_r`: pops 1 beat/cycle and `o_a1_r` returns the cycle after the first pop. No beat is lost or duplicated.
- **Simultaneous push and pop.** At count=1 with a push and pop in the same cycle → count stays 1 and data order is preserved across pointer wrap-around (≥5 beats).
- **Random.** Random valids and random `i_z_r` against a scoreboard keyed by `o_z_s`:
  - Each input's data arrives in order, and no grant is ever issued without its valid.
  - `o_a0_r` and `o_a1_r` are never high together.
  - Output valid and data hold while stalled.
